clk_period_meter: RTL and testbench

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

---
 rtl/clk_period_meter.sv | 148 ++++++++++++++
 tb/tb_clk_period_meter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// Measures the period and high time of an asynchronous signal in clk cycles,
// with one-shot or back-to-back operation and an abort limit.
module clk_period_meter #(
    parameter int          WIDTH   = 32,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             timeout,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] timer_q, timer_d;
    logic             rise;
    logic [WIDTH-1:0] s2_ext;

    // s3 only remembers the previous synchronized level for edge detection
    assign rise   = s2_q & ~s3_q;
    assign s2_ext = {{(WIDTH-1){1'b0}}, s2_q};

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        period_d  = period_q;
        high_d    = high_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        timer_d   = timer_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = WAIT_EDGE;
                    valid_d   = 1'b0;
                    timeout_d = 1'b0;
                    timer_d   = '0;
                end
            end
            WAIT_EDGE: begin
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = ONE;
                    hi_d    = ONE;
                end else if (timer_q == LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    valid_d   = 1'b0;
                end else begin
                    timer_d = timer_q + ONE;
                end
            end
            MEASURE: begin
                // An edge wins over an abort landing in the same cycle
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = hi_q;
                    valid_d  = 1'b1;
                    done_d   = 1'b1;
                    cnt_d    = ONE;
                    hi_d     = ONE;
                    if (!cont) begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    valid_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + ONE;
                    hi_d  = hi_q + s2_ext;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            s1_q      <= sig_in;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            period_q  <= period_d;
            high_q    <= high_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            timer_q   <= timer_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign period    = period_q;
    assign high_time = high_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: expected periods/high times come
// from the stimulus waveform segment lengths, not from the synchronizer/FSM.
module tb_clk_period_meter;

    localparam int WIDTH = 32;
    localparam int TO    = 100;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             cont;
    logic             man_sig;
    logic             div_en;
    logic             div_sig;
    logic             sig_in;
    logic             busy, done, valid, timeout;
    logic [WIDTH-1:0] period, high_time;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int cyc      = 0;
    int div_half = 5;
    int div_cnt  = 0;

    logic [WIDTH-1:0] q_p[$];
    logic [WIDTH-1:0] q_h[$];
    int               q_c[$];

    assign sig_in = div_en ? div_sig : man_sig;

    clk_period_meter #(.WIDTH(WIDTH), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .start    (start),
        .cont     (cont),
        .busy     (busy),
        .done     (done),
        .valid    (valid),
        .timeout  (timeout),
        .period   (period),
        .high_time(high_time)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Divider: toggles every div_half cycles, giving a period of 2*div_half
    always @(negedge clk) begin
        if (!div_en) begin
            div_cnt = 0;
            div_sig = 1'b0;
        end else begin
            div_cnt = div_cnt + 1;
            if (div_cnt == div_half) begin
                div_sig = ~div_sig;
                div_cnt = 0;
            end
        end
    end

    // Record every result presented with a done pulse
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            q_p.push_back(period);
            q_h.push_back(high_time);
            q_c.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_dones(input int target, input int budget);
        int b;
        b = budget;
        while (done_cnt < target && b > 0) begin
            @(negedge clk);
            b--;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b want=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%0b want=0", done); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid got=%0b want=0", valid); else n_pass++;
        n_checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout got=%0b want=0", timeout); else n_pass++;
        n_checks++; if (period !== '0) $display("FAIL reset_period got=%0d want=0", period); else n_pass++;
        n_checks++; if (high_time !== '0) $display("FAIL reset_high got=%0d want=0", high_time); else n_pass++;
        rst = 1'b0;
        man_sig = 1'b1;
        tick(3);
        man_sig = 1'b0;
        tick(6);
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_no_start_busy got=%0b want=0", busy); else n_pass++;
        n_checks++; if (done_cnt !== 0) $display("FAIL idle_no_start_done got=%0d want=0", done_cnt); else n_pass++;
    endtask

    task automatic test_single();
        int base;
        cont = 1'b0;
        div_half = 5;
        div_en = 1'b1;
        tick(3);
        base = done_cnt;
        pulse_start();
        n_checks++; if (busy !== 1'b1) $display("FAIL single_busy got=%0b want=1", busy); else n_pass++;
        wait_dones(base + 1, 60);
        n_checks++; if (done_cnt !== base + 1) $display("FAIL single_done_count got=%0d want=%0d", done_cnt - base, 1); else n_pass++;
        n_checks++; if (q_p.size() == 0 || q_p[$] !== 32'd10) $display("FAIL single_period got=%0d want=10", period); else n_pass++;
        n_checks++; if (q_h.size() == 0 || q_h[$] !== 32'd5) $display("FAIL single_high got=%0d want=5", high_time); else n_pass++;
        n_checks++; if (valid !== 1'b1) $display("FAIL single_valid got=%0b want=1", valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL single_idle got=%0b want=0", busy); else n_pass++;
        tick(40);
        n_checks++; if (done_cnt !== base + 1) $display("FAIL single_one_shot got=%0d want=%0d", done_cnt - base, 1); else n_pass++;
        div_en = 1'b0;
        tick(6);
    endtask

    task automatic test_continuous();
        int base;
        int n;
        cont = 1'b1;
        div_half = 2;
        div_en = 1'b1;
        tick(2);
        base = done_cnt;
        pulse_start();
        wait_dones(base + 5, 80);
        n_checks++; if (done_cnt !== base + 5) $display("FAIL cont_done_count got=%0d want=5", done_cnt - base); else n_pass++;
        n = q_p.size();
        if (n >= 5) begin
            for (int i = n - 5; i < n; i++) begin
                n_checks++; if (q_p[i] !== 32'd4) $display("FAIL cont_period[%0d] got=%0d want=4", i, q_p[i]); else n_pass++;
                n_checks++; if (q_h[i] !== 32'd2) $display("FAIL cont_high[%0d] got=%0d want=2", i, q_h[i]); else n_pass++;
                if (i > n - 5) begin
                    n_checks++;
                    if (q_c[i] - q_c[i-1] !== 4) $display("FAIL cont_spacing[%0d] got=%0d want=4", i, q_c[i] - q_c[i-1]);
                    else n_pass++;
                end
            end
        end
        cont = 1'b0;
        tick(20);
        n_checks++; if (done_cnt !== base + 6) $display("FAIL cont_stop_count got=%0d want=6", done_cnt - base); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL cont_stop_busy got=%0b want=0", busy); else n_pass++;
        n_checks++; if (period !== 32'd4) $display("FAIL cont_stop_period got=%0d want=4", period); else n_pass++;
        div_en = 1'b0;
        tick(6);
    endtask

    // Random high/low segment lengths; each measurement spans one high plus one low
    task automatic test_random_cont();
        localparam int K = 5;
        int h[K];
        int l[K];
        int base;
        int first;
        man_sig = 1'b0;
        cont = 1'b1;
        tick(2);
        base = done_cnt;
        first = q_p.size();
        pulse_start();
        tick(4);
        for (int i = 0; i < K; i++) begin
            h[i] = int'($urandom_range(1, 20));
            l[i] = (i == K - 1) ? int'($urandom_range(8, 20)) : int'($urandom_range(1, 20));
            man_sig = 1'b1;
            tick(h[i]);
            man_sig = 1'b0;
            if (i == K - 1) begin
                tick(4);
                cont = 1'b0;
                tick(l[i] - 4);
            end else begin
                tick(l[i]);
            end
        end
        man_sig = 1'b1;
        tick(6);
        man_sig = 1'b0;
        tick(10);
        n_checks++; if (done_cnt !== base + K) $display("FAIL rand_done_count got=%0d want=%0d", done_cnt - base, K); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rand_idle got=%0b want=0", busy); else n_pass++;
        if (q_p.size() >= first + K) begin
            for (int i = 0; i < K; i++) begin
                n_checks++;
                if (q_p[first+i] !== WIDTH'(h[i] + l[i]))
                    $display("FAIL rand_period[%0d] got=%0d want=%0d", i, q_p[first+i], h[i] + l[i]);
                else n_pass++;
                n_checks++;
                if (q_h[first+i] !== WIDTH'(h[i]))
                    $display("FAIL rand_high[%0d] got=%0d want=%0d", i, q_h[first+i], h[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_timeout_wait();
        logic [WIDTH-1:0] pre_p;
        man_sig = 1'b0;
        tick(4);
        pre_p = period;
        pulse_start();
        tick(TO - 1);
        n_checks++; if (busy !== 1'b1) $display("FAIL towait_busy_before got=%0b want=1", busy); else n_pass++;
        n_checks++; if (timeout !== 1'b0) $display("FAIL towait_early got=%0b want=0", timeout); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("FAIL towait_valid_cleared got=%0b want=0", valid); else n_pass++;
        tick(1);
        n_checks++; if (timeout !== 1'b1) $display("FAIL towait_timeout got=%0b want=1", timeout); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL towait_busy got=%0b want=0", busy); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("FAIL towait_valid got=%0b want=0", valid); else n_pass++;
        n_checks++; if (period !== pre_p) $display("FAIL towait_period got=%0d want=%0d", period, pre_p); else n_pass++;
    endtask

    task automatic test_timeout_measure();
        logic [WIDTH-1:0] pre_p;
        logic [WIDTH-1:0] pre_h;
        int base;
        man_sig = 1'b0;
        tick(3);
        pre_p = period;
        pre_h = high_time;
        base = done_cnt;
        pulse_start();
        n_checks++; if (timeout !== 1'b0) $display("FAIL tomeas_cleared got=%0b want=0", timeout); else n_pass++;
        tick(4);
        man_sig = 1'b1;
        tick(1);
        man_sig = 1'b0;
        tick(TO);
        n_checks++; if (busy !== 1'b1 || timeout !== 1'b0) $display("FAIL tomeas_before busy=%0b timeout=%0b want busy=1 timeout=0", busy, timeout); else n_pass++;
        tick(1);
        n_checks++; if (timeout !== 1'b1) $display("FAIL tomeas_timeout got=%0b want=1", timeout); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL tomeas_busy got=%0b want=0", busy); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("FAIL tomeas_valid got=%0b want=0", valid); else n_pass++;
        n_checks++; if (period !== pre_p) $display("FAIL tomeas_period got=%0d want=%0d", period, pre_p); else n_pass++;
        n_checks++; if (high_time !== pre_h) $display("FAIL tomeas_high got=%0d want=%0d", high_time, pre_h); else n_pass++;
        n_checks++; if (done_cnt !== base) $display("FAIL tomeas_no_done got=%0d want=0", done_cnt - base); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int base;
        man_sig = 1'b0;
        cont = 1'b0;
        tick(3);
        base = done_cnt;
        pulse_start();
        tick(3);
        man_sig = 1'b1;
        tick(5);
        man_sig = 1'b0;
        tick(4);
        n_checks++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before got=%0b want=1", busy); else n_pass++;
        rst = 1'b1;
        tick(1);
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%0b want=0", busy); else n_pass++;
        n_checks++; if (timeout !== 1'b0) $display("FAIL rstmid_timeout got=%0b want=0", timeout); else n_pass++;
        n_checks++; if (valid !== 1'b0 || done !== 1'b0) $display("FAIL rstmid_valid_done valid=%0b done=%0b want 0", valid, done); else n_pass++;
        n_checks++; if (period !== '0 || high_time !== '0) $display("FAIL rstmid_results period=%0d high=%0d want 0", period, high_time); else n_pass++;
        rst = 1'b0;
        div_half = 5;
        div_en = 1'b1;
        tick(60);
        n_checks++; if (done_cnt !== base) $display("FAIL rstmid_no_done got=%0d want=0", done_cnt - base); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_stays_idle got=%0b want=0", busy); else n_pass++;
        pulse_start();
        wait_dones(base + 1, 60);
        n_checks++; if (done_cnt !== base + 1) $display("FAIL rstmid_restart_count got=%0d want=1", done_cnt - base); else n_pass++;
        n_checks++; if (period !== 32'd10 || high_time !== 32'd5) $display("FAIL rstmid_restart period=%0d high=%0d want 10/5", period, high_time); else n_pass++;
        div_en = 1'b0;
        tick(6);
    endtask

    task automatic test_start_busy();
        int base;
        man_sig = 1'b0;
        cont = 1'b0;
        tick(6);
        base = done_cnt;
        pulse_start();
        tick(4);
        man_sig = 1'b1;
        tick(3);
        pulse_start();
        tick(1);
        man_sig = 1'b0;
        tick(2);
        pulse_start();
        tick(2);
        man_sig = 1'b1;
        tick(5);
        man_sig = 1'b0;
        tick(15);
        n_checks++; if (done_cnt !== base + 1) $display("FAIL startbusy_count got=%0d want=1", done_cnt - base); else n_pass++;
        n_checks++; if (period !== 32'd10) $display("FAIL startbusy_period got=%0d want=10", period); else n_pass++;
        n_checks++; if (high_time !== 32'd5) $display("FAIL startbusy_high got=%0d want=5", high_time); else n_pass++;
        n_checks++; if (busy !== 1'b0 || valid !== 1'b1) $display("FAIL startbusy_final busy=%0b valid=%0b want 0/1", busy, valid); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cont = 1'b0;
        man_sig = 1'b0;
        div_en = 1'b0;
        div_sig = 1'b0;
        test_reset();
        test_single();
        test_continuous();
        test_random_cont();
        test_timeout_wait();
        test_timeout_measure();
        test_reset_mid();
        test_start_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
